// File: rtl/instr_seq.sv
// instr_seq: fetch/decode/execute sequencer for the MPU-6050 I2C program ROM.
// Define INSTR_SEQ_LOOP_EN to restart the program at address 0 after every END.
module instr_seq #(
    parameter int ADDR_ROM_SZ = 4,
    parameter int DATA_ROM_SZ = 16,
    parameter int DLY_SZ      = 16
) (
    input  logic                   CLK,
    input  logic                   RST_n,
    input  logic                   I_START,
    output logic [ADDR_ROM_SZ-1:0] O_ADDR_ROM_A,
    output logic [ADDR_ROM_SZ-1:0] O_ADDR_ROM_B,
    input  logic [DATA_ROM_SZ-1:0] I_DATA_ROM_A,
    input  logic [DATA_ROM_SZ-1:0] I_DATA_ROM_B,
    output logic                   O_CMD_VLD,
    input  logic                   I_CMD_RDY,
    output logic                   O_CMD_RW,
    output logic [7:0]             O_CMD_REG,
    output logic [7:0]             O_CMD_DATA,
    output logic [3:0]             O_CMD_NUM,
    input  logic                   I_CMD_DONE,
    input  logic                   I_CMD_ERR,
    output logic                   O_BUSY,
    output logic                   O_DONE,
    output logic                   O_ERR
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_DECODE    = 3'd2;
    localparam logic [2:0] S_ISSUE     = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;
    localparam logic [2:0] S_DELAY     = 3'd5;
    localparam logic [2:0] S_FINISH    = 3'd6;
    localparam logic [3:0] OP_END  = 4'h0;
    localparam logic [3:0] OP_WR   = 4'h1;
    localparam logic [3:0] OP_RD   = 4'h2;
    localparam logic [3:0] OP_WAIT = 4'h3;
    // address of the last instruction slot; finishing it is an implicit END
    localparam logic [ADDR_ROM_SZ-1:0] PC_LAST = ~ADDR_ROM_SZ'(1);
`ifdef INSTR_SEQ_LOOP_EN
    localparam logic LOOP = 1'b1;
`else
    localparam logic LOOP = 1'b0;
`endif

    logic [2:0]             state, state_nx;
    logic [ADDR_ROM_SZ-1:0] pc, pc_nx;
    logic [DLY_SZ-1:0]      dly, dly_nx, dly_ld;
    logic [3:0]             op;
    logic                   done_nx, err_nx, load, adv, stop, abort;

    assign op     = I_DATA_ROM_A[15:12];
    assign dly_ld = I_DATA_ROM_B[DLY_SZ-1:0];

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        dly_nx   = dly;
        done_nx  = 1'b0;
        err_nx   = O_ERR;
        load     = 1'b0;
        adv      = 1'b0;
        stop     = 1'b0;
        abort    = 1'b0;
        case (state)
            S_IDLE: begin
                pc_nx = '0;
                if (I_START) begin
                    err_nx   = 1'b0;
                    state_nx = S_FETCH;
                end
            end
            S_FETCH: state_nx = S_DECODE;
            S_DECODE: begin
                if (op == OP_END) begin
                    stop = 1'b1;
                end else if (op == OP_WR || op == OP_RD) begin
                    load     = 1'b1;
                    state_nx = S_ISSUE;
                end else if (op == OP_WAIT && dly_ld != '0) begin
                    dly_nx   = dly_ld;
                    state_nx = S_DELAY;
                end else begin
                    adv = 1'b1;
                end
            end
            S_ISSUE: state_nx = I_CMD_RDY ? S_WAIT_DONE : S_ISSUE;
            S_WAIT_DONE: begin
                abort  = I_CMD_DONE && I_CMD_ERR;
                adv    = I_CMD_DONE && !I_CMD_ERR;
                err_nx = O_ERR || abort;
            end
            S_DELAY: begin
                adv    = dly <= DLY_SZ'(1);
                dly_nx = dly - DLY_SZ'(1);
            end
            S_FINISH: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (adv && pc != PC_LAST) begin
            pc_nx    = pc + ADDR_ROM_SZ'(2);
            state_nx = S_FETCH;
        end
        // program end: explicit END, running off the ROM, or a NACK abort
        if (stop || abort || (adv && pc == PC_LAST)) begin
            done_nx  = 1'b1;
            pc_nx    = '0;
            state_nx = (LOOP && !abort) ? S_FETCH : S_FINISH;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state      <= S_IDLE;
            pc         <= '0;
            dly        <= '0;
            O_DONE     <= 1'b0;
            O_ERR      <= 1'b0;
            O_CMD_RW   <= 1'b0;
            O_CMD_REG  <= '0;
            O_CMD_DATA <= '0;
            O_CMD_NUM  <= '0;
        end else begin
            state  <= state_nx;
            pc     <= pc_nx;
            dly    <= dly_nx;
            O_DONE <= done_nx;
            O_ERR  <= err_nx;
            if (load) begin
                O_CMD_RW   <= op == OP_RD;
                O_CMD_REG  <= I_DATA_ROM_A[7:0];
                O_CMD_DATA <= I_DATA_ROM_B[7:0];
                O_CMD_NUM  <= I_DATA_ROM_A[11:8];
            end
        end
    end

    assign O_ADDR_ROM_A = pc;
    assign O_ADDR_ROM_B = pc + ADDR_ROM_SZ'(1);
    assign O_CMD_VLD    = state == S_ISSUE;
    assign O_BUSY       = state != S_IDLE;
endmodule

// File: tb/tb_instr_seq.sv
// tb_instr_seq: table vectors, reset/loop sequences and random programs checked
// against a program-walking reference model of instr_seq.
module tb_instr_seq;
`ifdef INSTR_SEQ_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    typedef struct packed {
        logic       rw;
        logic [7:0] rg;
        logic [7:0] dt;
        logic [3:0] nm;
    } cmd_t;

    typedef struct {
        logic [15:0] a0, b0, a1, b1;
        int          r;
        logic [31:0] em;
        int          poke;
        int          n;
        int          vc;
        int          dc;
        logic        e;
        logic [20:0] k;
    } vec_t;

    logic clk = 0, rst_n = 0, start = 0, rdy = 0, resp_en = 1;
    logic resp_done = 0, resp_err = 0, poke_done = 0, poke_err = 0;
    logic cmd_done, cmd_err;
    logic [3:0] addr_a, addr_b, nm;
    logic [15:0] data_a = 0, data_b = 0;
    logic vld, rw, busy, done, err;
    logic [7:0] rg, dt;
    logic [15:0] rom [16];

    int tests = 0, fails = 0, cyc = 0, t0 = 0, first_vld = -1;
    int rdy_wait = 0, done_wait = 2;
    logic [31:0] err_mask = 0;
    cmd_t cmds[$];
    cmd_t exp_q[$];
    int act_done, act_pulses, exp_done, exp_first;
    bit act_busy_ok;
    logic exp_err;
    vec_t tbl [8];

    assign cmd_done = resp_done | poke_done;
    assign cmd_err  = resp_err | poke_err;

    instr_seq dut (
        .CLK(clk), .RST_n(rst_n), .I_START(start),
        .O_ADDR_ROM_A(addr_a), .O_ADDR_ROM_B(addr_b),
        .I_DATA_ROM_A(data_a), .I_DATA_ROM_B(data_b),
        .O_CMD_VLD(vld), .I_CMD_RDY(rdy), .O_CMD_RW(rw), .O_CMD_REG(rg),
        .O_CMD_DATA(dt), .O_CMD_NUM(nm), .I_CMD_DONE(cmd_done), .I_CMD_ERR(cmd_err),
        .O_BUSY(busy), .O_DONE(done), .O_ERR(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        data_a <= rom[addr_a];
        data_b <= rom[addr_b];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string nm_s, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm_s, act, exp);
        end
    endtask

    function automatic logic [20:0] key(input cmd_t c);
        return {c.rw, c.rg, c.rw ? 8'h00 : c.dt, c.rw ? c.nm : 4'h0};
    endfunction

    // I2C master stand-in: holds RDY low rdy_wait cycles, pulses DONE done_wait cycles later
    initial begin
        cmd_t cap;
        forever begin
            @(negedge clk);
            if (resp_en && vld) begin
                cap = '{rw, rg, dt, nm};
                if (first_vld < 0) first_vld = cyc - t0;
                for (int j = 0; j < rdy_wait; j++) begin
                    @(negedge clk);
                    check("vld_hold", {vld, rw, rg, dt, nm}, {1'b1, cap});
                end
                rdy = 1;
                @(negedge clk);
                rdy = 0;
                check("vld_drop", vld, 0);
                cmds.push_back(cap);
                repeat (done_wait) @(negedge clk);
                resp_done = 1;
                resp_err  = err_mask[cmds.size() - 1];
                @(negedge clk);
                resp_done = 0;
                resp_err  = 0;
            end
        end
    end

    task automatic do_reset();
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic exec(input int poke);
        cmds.delete();
        first_vld   = -1;
        act_done    = -1;
        act_pulses  = 0;
        act_busy_ok = 1;
        @(negedge clk);
        start = 1;
        t0 = cyc;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            start     = (i == poke);
            poke_done = (i == poke);
            poke_err  = (i == poke);
            if (i == 1) check("err_clear", err, 0);
            if (done) begin
                act_pulses++;
                if (act_done < 0) act_done = i;
            end
            if (busy !== (act_done < 0 || i <= act_done)) act_busy_ok = 0;
            if (act_done >= 0 && (LOOP || i >= act_done + 3)) break;
        end
        start     = 0;
        poke_done = 0;
        poke_err  = 0;
    endtask

    // walks the ROM image instruction by instruction, accumulating cycle costs
    task automatic model(input int r, input int dw, input logic [31:0] em);
        int pc, f, n, nf;
        logic [15:0] a, b;
        cmd_t c;
        exp_q.delete();
        exp_err = 0; exp_done = -1; exp_first = -1;
        pc = 0; f = 1; n = 0; nf = 0;
        while (exp_done < 0) begin
            a = rom[pc];
            b = rom[pc + 1];
            case (a[15:12])
                4'h0: exp_done = f + 2;
                4'h1, 4'h2: begin
                    if (exp_first < 0) exp_first = f + 2;
                    c = '{a[15:12] == 4'h2, a[7:0], b[7:0], a[11:8]};
                    exp_q.push_back(c);
                    nf = f + 2 + r + 1 + dw + 1;
                    if (em[n]) begin
                        exp_err  = 1;
                        exp_done = nf;
                    end
                    n++;
                end
                4'h3: nf = f + 2 + int'(b);
                default: nf = f + 2;
            endcase
            if (exp_done < 0) begin
                pc += 2;
                if (pc >= 16) exp_done = nf;
                else f = nf;
            end
        end
    endtask

    task automatic run_vs_model(input string tag);
        model(rdy_wait, done_wait, err_mask);
        exec(0);
        check({tag, "_ncmd"}, cmds.size(), exp_q.size());
        for (int j = 0; j < exp_q.size() && j < cmds.size(); j++)
            check({tag, "_cmd"}, key(cmds[j]), key(exp_q[j]));
        check({tag, "_done_cyc"}, act_done, exp_done);
        check({tag, "_first_vld"}, first_vld, exp_first);
        check({tag, "_err"}, err, exp_err);
        check({tag, "_pulses"}, act_pulses, 1);
        check({tag, "_busy"}, act_busy_ok, 1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 16'h0;
        tbl[0] = '{16'h106B, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0,  1, 3,   9,   1'b0, {1'b0, 8'h6B, 8'h00, 4'h0}};
        tbl[1] = '{16'h2D3B, 16'h0000, 16'h0000, 16'h0000, 5, 0, 0,  1, 3,   14,  1'b0, {1'b1, 8'h3B, 8'h00, 4'hD}};
        tbl[2] = '{16'h3000, 16'd100,  16'h101C, 16'h0008, 0, 0, 0,  1, 105, 111, 1'b0, {1'b0, 8'h1C, 8'h08, 4'h0}};
        tbl[3] = '{16'h106B, 16'h0000, 16'h1019, 16'h0005, 0, 1, 0,  1, 3,   7,   1'b1, {1'b0, 8'h6B, 8'h00, 4'h0}};
        tbl[4] = '{16'h5000, 16'hFFFF, 16'h1019, 16'h0007, 0, 0, 0,  1, 5,   11,  1'b0, {1'b0, 8'h19, 8'h07, 4'h0}};
        tbl[5] = '{16'h3000, 16'h0000, 16'h2123, 16'h00AA, 0, 0, 0,  1, 5,   11,  1'b0, {1'b1, 8'h23, 8'h00, 4'h1}};
        tbl[6] = '{16'h0000, 16'h0000, 16'h106B, 16'h0000, 0, 0, 0,  0, -1,  3,   1'b0, 21'h0};
        tbl[7] = '{16'h3000, 16'd20,   16'h106C, 16'h0001, 0, 0, 10, 1, 25,  31,  1'b0, {1'b0, 8'h6C, 8'h01, 4'h0}};

        do_reset();
        check("rst_addr", {addr_a, addr_b}, 8'h01);
        check("rst_cmd", {vld, rw, rg, dt, nm}, 0);
        check("rst_status", {busy, done, err}, 0);

        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < 16; i++) rom[i] = 16'h0;
            rom[0] = tbl[v].a0; rom[1] = tbl[v].b0; rom[2] = tbl[v].a1; rom[3] = tbl[v].b1;
            rdy_wait = tbl[v].r; done_wait = 2; err_mask = tbl[v].em;
            exec(tbl[v].poke);
            check($sformatf("vec%0d_ncmd", v), cmds.size(), tbl[v].n);
            check($sformatf("vec%0d_first_vld", v), first_vld, tbl[v].vc);
            check($sformatf("vec%0d_done_cyc", v), act_done, tbl[v].dc);
            check($sformatf("vec%0d_err", v), err, tbl[v].e);
            check($sformatf("vec%0d_pulses", v), act_pulses, 1);
            check($sformatf("vec%0d_busy", v), act_busy_ok, 1);
            if (tbl[v].n > 0)
                check($sformatf("vec%0d_cmd", v), cmds.size() > 0 ? key(cmds[0]) : 21'h1FFFFF, tbl[v].k);
            if (LOOP) do_reset();
        end

        // asynchronous reset while a command is being offered
        for (int i = 0; i < 16; i++) rom[i] = 16'h0;
        rom[0] = 16'h106B;
        rdy_wait = 0; done_wait = 2; err_mask = 0;
        resp_en = 0;
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (2) @(negedge clk);
        check("mid_vld", {vld, rg}, {1'b1, 8'h6B});
        #2 rst_n = 0;
        #1;
        check("mid_rst_vld", vld, 0);
        check("mid_rst_addr", {addr_a, addr_b}, 8'h01);
        check("mid_rst_busy", {busy, rg}, 0);
        @(negedge clk);
        rst_n = 1;
        resp_en = 1;
        exec(0);
        check("rerun_ncmd", cmds.size(), 1);
        check("rerun_cmd", cmds.size() > 0 ? key(cmds[0]) : 21'h1FFFFF, {1'b0, 8'h6B, 8'h00, 4'h0});
        check("rerun_done_cyc", act_done, 9);
        if (LOOP) do_reset();

        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < 8; i++) begin
                int k;
                logic [3:0] op;
                k = $urandom_range(0, 11);
                op = (k == 0) ? 4'h0 : (k <= 4) ? 4'h1 : (k <= 7) ? 4'h2 : (k <= 9) ? 4'h3 : 4'($urandom_range(4, 15));
                rom[2*i] = {op, 12'($urandom)};
                rom[2*i+1] = (op == 4'h3) ? 16'($urandom_range(0, 6)) : 16'($urandom);
            end
            rdy_wait  = $urandom_range(0, 3);
            done_wait = $urandom_range(0, 3);
            err_mask  = ($urandom_range(0, 3) == 0) ? (32'h1 << $urandom_range(0, 7)) : 32'h0;
            run_vs_model("rnd");
            if (LOOP) do_reset();
        end

        // full ROM of writes with no END
        for (int i = 0; i < 8; i++) begin
            rom[2*i] = 16'h1010 + 16'(i);
            rom[2*i+1] = 16'(i * 3);
        end
        rdy_wait = 1; done_wait = 1; err_mask = 0;
        run_vs_model("full");
        if (LOOP) begin
            for (int i = 0; i < 100 && cmds.size() < 9; i++) @(negedge clk);
            check("loop_9th_seen", cmds.size() >= 9, 1);
            check("loop_9th_reg", cmds.size() >= 9 ? cmds[8].rg : 8'h00, 8'h10);
            check("loop_busy", busy, 1);
            do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/instr_seq.md
# instr_seq

Instruction sequencer that fetches and executes the MPU-6050 init/poll program from the 16-bit instruction ROM. It drives both ROM read ports, one instruction (two consecutive words) per fetch. It decodes each instruction into an I2C register write, burst read or delay, and hands commands to the I2C master over a valid/ready handshake, then waits for completion. It sits between the instruction ROM and the I2C master and is started by the top-level control.

## Interface
- ADDR_ROM_SZ, 4, ROM address width (program = 2**ADDR_ROM_SZ words)
- DATA_ROM_SZ, 16, ROM word width (fixed 16 for this decoder)
- DLY_SZ, 16, delay counter width
- CLK  in  1  clock 50 MHz
- RST_n  in  1  asynchronous active-low reset
- I_START  in  1  pulse: start program at address 0
- O_ADDR_ROM_A  out  ADDR_ROM_SZ  word A address (= PC)
- O_ADDR_ROM_B  out  ADDR_ROM_SZ  word B address (= PC+1, mod 2**ADDR_ROM_SZ)
- I_DATA_ROM_A  in  DATA_ROM_SZ  word A, valid 1 cycle after address
- I_DATA_ROM_B  in  DATA_ROM_SZ  word B, valid 1 cycle after address
- O_CMD_VLD  out  1  command valid
- I_CMD_RDY  in  1  I2C master accepts command
- O_CMD_RW  out  1  1 = read, 0 = write
- O_CMD_REG  out  8  MPU register address
- O_CMD_DATA  out  8  write data
- O_CMD_NUM  out  4  read byte count minus 1
- I_CMD_DONE  in  1  pulse: transaction finished
- I_CMD_ERR  in  1  NACK flag, qualified by I_CMD_DONE
- O_BUSY  out  1  program running
- O_DONE  out  1  pulse: program ended or aborted
- O_ERR  out  1  sticky error

## Operation
- Word A: [15:12] opcode, [11:8] NUM, [7:0] REG. Word B: [7:0] write data; for WAIT, [15:0] delay cycles (low DLY_SZ bits).
- Opcodes: 0x0 END; 0x1 WR (RW=0, DATA=B[7:0]); 0x2 RD (RW=1, NUM=A[11:8]); 0x3 WAIT; 0x4–0xF reserved → treated as NOP (PC += 2).
- FSM: IDLE → FETCH → DECODE → {ISSUE → WAIT_DONE | DELAY | FETCH (NOP) | FINISH}.
- IDLE: PC=0; I_START → clear O_ERR, FETCH.
- FETCH: PC on ROM ports; one cycle.
- DECODE: ROM data valid; load command registers / delay counter.
- ISSUE: O_CMD_VLD=1, payload stable until I_CMD_RDY=1 sampled; then WAIT_DONE.
- WAIT_DONE: on I_CMD_DONE: if I_CMD_ERR set O_ERR, go FINISH; else PC+=2, FETCH.
- DELAY: count N cycles then PC+=2, FETCH; N=0 → straight to FETCH.
- FINISH: one cycle, O_DONE=1, then IDLE.
- PC advances by 2; after the instruction at PC = 2**ADDR_ROM_SZ−2 completes, implicit END (no wrap execution).
- I_START while busy ignored. I_CMD_DONE outside WAIT_DONE ignored.

## Timing
- Reset values: O_ADDR_ROM_A=0, O_ADDR_ROM_B=1, O_CMD_VLD=0, O_CMD_RW=0, O_CMD_REG=0, O_CMD_DATA=0, O_CMD_NUM=0, O_BUSY=0, O_DONE=0, O_ERR=0, state IDLE.
- Reset mid-operation: all outputs return to reset values asynchronously; O_CMD_VLD drops immediately.
- I_START at cycle 0 → FETCH cycle 1 → DECODE cycle 2 → O_CMD_VLD=1 cycle 3.
- I_CMD_RDY=1 at cycle 3 → O_CMD_VLD=0 cycle 4.
- I_CMD_DONE at cycle k → next FETCH at k+1.
- O_BUSY=1 from cycle 1 through FINISH; 0 in IDLE.
- O_DONE exactly one cycle.
- O_ERR holds until next accepted I_START.

## Configuration
- INSTR_SEQ_LOOP_EN defined: END (explicit or implicit) sets PC=0 and enters FETCH; O_DONE pulses once per pass; O_BUSY stays 1. An error still aborts to FINISH/IDLE.
- Undefined: END → FINISH → IDLE, one O_DONE, waits for I_START.

## Test plan
- Program WR(0x6B, 0x00), END: I_START → cycle 3 VLD=1, RW=0, REG=0x6B, DATA=0x00; DONE → O_DONE one pulse, BUSY=0.
- RD(0x3B, NUM=13) with RDY held low 5 cycles: VLD and payload stable 5 cycles, RW=1, NUM=13; one transfer.
- WAIT 100 then WR: no VLD for 100 cycles after DECODE; WR VLD at DECODE+100+3.
- I_CMD_DONE with I_CMD_ERR=1 on first WR: O_ERR=1, O_DONE pulse, IDLE; next I_START clears O_ERR.
- RST_n low during ISSUE: VLD=0 immediately, PC=0; after release, I_START reruns from address 0.
- Full ROM of 8 WRs, no END: 8 commands, then O_DONE; with INSTR_SEQ_LOOP_EN, 9th command REG equals first.
